iic_slave_core: RTL and testbench
=================================

IIC_SLAVE_CORE -- requirements
Module: iic_slave_core

Interface
REQ-001 Parameter SLV_ADDR, default 7'h50, the 7-bit I2C target address matched after START.
REQ-002 Parameter SYNC_STAGES, default 2, the synchronizer depth for iic_scl_i/iic_sda_i (legal 2..3).
REQ-003 clk  input  1  the single clock for all logic; iic_scl_i is oversampled on it.
REQ-004 iic_rst  input  1  reset, synchronous, active-high.
REQ-005 iic_en  input  1  1 = target responds on the bus; 0 = SDA released, FSM held in IDLE.
REQ-006 iic_scl_i  input  1  bus SCL, asynchronous.
REQ-007 iic_sda_i  input  1  bus SDA, asynchronous.
REQ-008 iic_sda_o  output  1  SDA drive value; constant 0 (open-drain).
REQ-009 iic_sda_out  output  1  SDA output enable; 1 = pull SDA low.
REQ-010 rx_data  output  8  last byte written by the controller.
REQ-011 rx_vld  output  1  one-cycle pulse; rx_data is valid.
REQ-012 tx_data  input  8  byte to return on a read; sampled when tx_req pulses.
REQ-013 tx_req  output  1  one-cycle pulse; tx_data captured into the shift register.
REQ-014 iic_rw  output  1  R/W bit of the last matched address byte.
REQ-015 iic_busy  output  1  high from the matched address ACK until STOP or a non-matching START.
REQ-016 iic_stop  output  1  one-cycle pulse on STOP detection while iic_busy.

Function
REQ-017 Synchronized SCL/SDA SHALL feed edge detectors; scl_rise/scl_fall are one-cycle pulses.
REQ-018 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both take priority over bit events in the same cycle.
REQ-019 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-020 START in any state -> ADDR, bit counter = 0, iic_sda_out = 0 (repeated START supported).
REQ-021 STOP in any state -> IDLE, iic_sda_out = 0.
REQ-022 Data bits are sampled on scl_rise, MSB first; a 3-bit counter counts 0..7.
REQ-023 ADDR: after the 8th scl_rise, on address match -> ADDR_ACK and latch iic_rw; no match -> IDLE, SDA untouched.
REQ-024 ACK slot: iic_sda_out asserts on the scl_fall after the 8th bit and releases on the following scl_fall.
REQ-025 ADDR_ACK exit: rw=0 -> WR_DATA; rw=1 -> RD_DATA, with tx_req pulsed on the ACK-release scl_fall and tx_data loaded in the same cycle.
REQ-026 WR_DATA: after the 8th bit, rx_data is updated and rx_vld pulses in that scl_rise cycle +1; -> WR_ACK (always ACK); then -> WR_DATA.
REQ-027 RD_DATA: iic_sda_out = ~shift[7] updated on each scl_fall; after the 8th bit's scl_fall, SDA is released -> RD_ACK.
REQ-028 RD_ACK: SDA sampled at scl_rise; 0 (ACK) -> on next scl_fall pulse tx_req, load tx_data, -> RD_DATA; 1 (NACK) -> IDLE, SDA released.
REQ-029 iic_en low mid-transfer SHALL force IDLE and iic_sda_out = 0 on the next cycle, with no rx_vld or tx_req.
REQ-030 The core SHALL never drive SCL; clock stretching is not supported.

Reset
REQ-031 On iic_rst: state IDLE; iic_sda_out = 0; rx_data = 8'h00; rx_vld = tx_req = iic_stop = 0; iic_rw = 0; iic_busy = 0; synchronizers preset to 1 (bus idle).
REQ-032 Reset asserted mid-byte SHALL abort silently; the next START is processed normally.

Configuration
REQ-033 Macro IIC_SLAVE_GLITCH_FILTER_EN defined: a 3-sample majority filter follows each synchronizer, adding 2 clk latency and rejecting pulses of 1 clk or less.
REQ-034 Macro undefined: no filter; edges are detected directly on synchronizer outputs.

Verification
REQ-035 Write: START, 0xA0, 0x3C, STOP -> both ACKs driven low, rx_vld once with rx_data = 8'h3C, iic_stop pulse, iic_busy low afterwards.
REQ-036 Read: START, 0xA1, tx_data = 8'h96, controller ACK then NACK -> bus bytes 0x96 then current tx_data, tx_req pulsed twice, IDLE after NACK.
REQ-037 Address mismatch: START, 0xA2, 0x55, STOP -> iic_sda_out never asserted, no rx_vld, iic_busy stays 0.
REQ-038 Repeated START: START, 0xA0, 0x10, Sr, 0xA1, read 1 byte NACK, STOP -> rx_data = 8'h10, iic_rw = 1, one read byte returned.
REQ-039 Abort: iic_rst or iic_en = 0 after 4 bits of a write byte -> SDA released within 1 clk; the following START, 0xA0, 0x01 -> ACK and rx_data = 8'h01.
REQ-040 With IIC_SLAVE_GLITCH_FILTER_EN: a 1-clk SCL low glitch during a data bit -> no extra bit is counted and the byte is received correctly.

Source files
------------

// File: rtl/iic_slave_core.sv
// rtl/iic_slave_core.sv - oversampled I2C target core with byte rx/tx handshake
// Optional majority glitch filter on SCL/SDA enabled by IIC_SLAVE_GLITCH_FILTER_EN.
module iic_slave_core #(
  parameter logic [6:0] SLV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       iic_rst,
  input  logic       iic_en,
  input  logic       iic_scl_i,
  input  logic       iic_sda_i,
  output logic       iic_sda_o,
  output logic       iic_sda_out,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       iic_rw,
  output logic       iic_busy,
  output logic       iic_stop
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_c, sda_c, scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d, byte_in;
  logic       sda_out_q, sda_out_d, ph_q, ph_d, nack_q, nack_d;
  logic       rx_vld_q, rx_vld_d, stop_q, stop_d, rw_q, rw_d, busy_q, busy_d, tx_load;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], iic_scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], iic_sda_i};
  end

  always_ff @(posedge clk) begin
    if (iic_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
  logic       scl_s, sda_s;

  // Majority over the current and two previous samples; a lone sample never wins.
  always_comb begin
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_hist_d = {scl_hist_q[0], scl_s};
    sda_hist_d = {sda_hist_q[0], sda_s};
    scl_flt_d  = (scl_s & scl_hist_q[0]) | (scl_s & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
    sda_flt_d  = (sda_s & sda_hist_q[0]) | (sda_s & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
  end

  always_ff @(posedge clk) begin
    if (iic_rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_flt_q  <= scl_flt_d;
      sda_flt_q  <= sda_flt_d;
    end
  end

  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = sda_prev_q & ~sda_c & scl_c & scl_prev_q;
  assign stop_det  = ~sda_prev_q & sda_c & scl_c & scl_prev_q;
  assign byte_in   = {shift_q[6:0], sda_c};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sda_out_d = sda_out_q;
    ph_d      = ph_q;
    nack_d    = nack_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    stop_d    = 1'b0;
    rw_d      = rw_q;
    busy_d    = busy_q;
    tx_load   = 1'b0;
    if (!iic_en) begin
      state_d   = IDLE;
      sda_out_d = 1'b0;
      ph_d      = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      cnt_d     = 3'd0;
      sda_out_d = 1'b0;
      ph_d      = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      sda_out_d = 1'b0;
      ph_d      = 1'b0;
      if (busy_q) begin
        stop_d = 1'b1;
        busy_d = 1'b0;
      end
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_in[7:1] == SLV_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = byte_in[0];
              ph_d    = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        // ph_q marks that the ACK is already being driven on the bus.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ph_q) begin
            sda_out_d = 1'b1;
            ph_d      = 1'b1;
            busy_d    = 1'b1;
          end else begin
            sda_out_d = 1'b0;
            ph_d      = 1'b0;
            cnt_d     = 3'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d   = RD_DATA;
              tx_load   = 1'b1;
              shift_d   = tx_data;
              sda_out_d = ~tx_data[7];
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d = byte_in;
            rx_vld_d  = 1'b1;
            state_d   = WR_ACK;
            ph_d      = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) ph_d = 1'b1;
          end else if (scl_fall) begin
            if (ph_q) begin
              sda_out_d = 1'b0;
              ph_d      = 1'b0;
              state_d   = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_out_d = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            nack_d = sda_c;
            ph_d   = 1'b1;
          end else if (scl_fall && ph_q) begin
            ph_d = 1'b0;
            if (!nack_q) begin
              state_d   = RD_DATA;
              tx_load   = 1'b1;
              shift_d   = tx_data;
              sda_out_d = ~tx_data[7];
              cnt_d     = 3'd0;
            end else begin
              state_d   = IDLE;
              sda_out_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (iic_rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      sda_out_q  <= 1'b0;
      ph_q       <= 1'b0;
      nack_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_vld_q   <= 1'b0;
      stop_q     <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_out_q  <= sda_out_d;
      ph_q       <= ph_d;
      nack_q     <= nack_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      stop_q     <= stop_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  assign iic_sda_o   = 1'b0;
  assign iic_sda_out = sda_out_q;
  assign rx_data     = rx_data_q;
  assign rx_vld      = rx_vld_q;
  assign tx_req      = tx_load & ~iic_rst;
  assign iic_rw      = rw_q;
  assign iic_busy    = busy_q;
  assign iic_stop    = stop_q;
endmodule

// File: tb/tb_iic_slave_core.sv
// tb/tb_iic_slave_core.sv - bus-level bench for iic_slave_core against a transaction model
module tb_iic_slave_core;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       iic_rst, iic_en, scl_drv, ctrl_sda;
  logic [7:0] tx_data;
  logic       iic_sda_o, iic_sda_out, rx_vld, tx_req, iic_rw, iic_busy, iic_stop;
  logic [7:0] rx_data;
  logic       bus_sda;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_seen[$];
  logic [7:0] tx_seen[$];
  int         stop_seen;
  bit         drive_seen;

  assign bus_sda = ctrl_sda & ~iic_sda_out;

  always #5 clk = ~clk;

  iic_slave_core #(.SLV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .iic_rst(iic_rst), .iic_en(iic_en),
    .iic_scl_i(scl_drv), .iic_sda_i(bus_sda),
    .iic_sda_o(iic_sda_o), .iic_sda_out(iic_sda_out),
    .rx_data(rx_data), .rx_vld(rx_vld), .tx_data(tx_data), .tx_req(tx_req),
    .iic_rw(iic_rw), .iic_busy(iic_busy), .iic_stop(iic_stop)
  );

  always @(negedge clk) begin
    if (rx_vld) rx_seen.push_back(rx_data);
    if (tx_req) tx_seen.push_back(tx_data);
    if (iic_stop) stop_seen++;
    if (iic_sda_out) drive_seen = 1'b1;
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_seen.delete();
    tx_seen.delete();
    stop_seen  = 0;
    drive_seen = 1'b0;
  endtask

  task automatic bus_start();
    ctrl_sda = 1'b1; wq();
    scl_drv  = 1'b1; wq();
    ctrl_sda = 1'b0; wq();
    scl_drv  = 1'b0; wq();
  endtask

  task automatic bus_stop();
    ctrl_sda = 1'b0; wq();
    scl_drv  = 1'b1; wq();
    ctrl_sda = 1'b1; wq(); wq();
  endtask

  task automatic put_bit(input logic b, input bit glitch);
    ctrl_sda = b; wq();
    scl_drv  = 1'b1; wq();
    if (glitch) begin
      scl_drv = 1'b0;
      @(negedge clk);
      scl_drv = 1'b1;
    end
    wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack, input int glitch_bit = -1);
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
    ctrl_sda = 1'b1; wq();
    scl_drv  = 1'b1; wq();
    ack      = ~bus_sda; wq();
    scl_drv  = 1'b0; wq();
  endtask

  task automatic read_byte(output logic [7:0] d, input bit ack);
    for (int i = 7; i >= 0; i--) begin
      ctrl_sda = 1'b1; wq();
      scl_drv  = 1'b1; wq();
      d[i]     = bus_sda; wq();
      scl_drv  = 1'b0; wq();
    end
    put_bit(~ack, 1'b0);
  endtask

  task automatic test_reset();
    iic_rst = 1'b1; iic_en = 1'b1; scl_drv = 1'b1; ctrl_sda = 1'b1; tx_data = 8'h00;
    repeat (5) @(negedge clk);
    checks++; if (iic_sda_out !== 1'b0) begin errors++; $display("FAIL reset_sda_out: got %b expected 0", iic_sda_out); end
    checks++; if (iic_sda_o !== 1'b0) begin errors++; $display("FAIL reset_sda_o: got %b expected 0", iic_sda_o); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_vld !== 1'b0) begin errors++; $display("FAIL reset_rx_vld: got %b expected 0", rx_vld); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
    checks++; if (iic_stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b expected 0", iic_stop); end
    checks++; if (iic_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b expected 0", iic_rw); end
    checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", iic_busy); end
    iic_rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] exp_q[$];
    bit ack;
    int nack_cnt = 0;
    exp_q = '{8'h3C, 8'h00, 8'hFF, 8'($urandom)};
    clear_mon();
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_addr_ack: got %b expected 1", ack); end
    foreach (exp_q[i]) begin
      write_byte(exp_q[i], ack);
      if (!ack) nack_cnt++;
    end
    checks++; if (nack_cnt != 0) begin errors++; $display("FAIL write_data_acks: got %0d nacks expected 0", nack_cnt); end
    checks++; if (iic_busy !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b expected 1", iic_busy); end
    bus_stop();
    checks++; if (rx_seen.size() != exp_q.size()) begin errors++; $display("FAIL write_rx_count: got %0d expected %0d", rx_seen.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_seen.size(); i++) begin
      checks++; if (rx_seen[i] !== exp_q[i]) begin errors++; $display("FAIL write_rx_byte%0d: got %h expected %h", i, rx_seen[i], exp_q[i]); end
    end
    checks++; if (stop_seen != 1) begin errors++; $display("FAIL write_stop_pulse: got %0d expected 1", stop_seen); end
    checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL write_busy_end: got %b expected 0", iic_busy); end
    checks++; if (iic_rw !== 1'b0) begin errors++; $display("FAIL write_rw: got %b expected 0", iic_rw); end
  endtask

  task automatic test_read();
    logic [7:0] tx1, b0, b1;
    bit ack;
    clear_mon();
    tx_data = 8'h96;
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
    tx1 = 8'($urandom);
    tx_data = tx1;
    read_byte(b0, 1'b1);
    tx_data = ~tx1;
    read_byte(b1, 1'b0);
    checks++; if (b0 !== 8'h96) begin errors++; $display("FAIL read_byte0: got %h expected 96", b0); end
    checks++; if (b1 !== tx1) begin errors++; $display("FAIL read_byte1: got %h expected %h", b1, tx1); end
    checks++; if (tx_seen.size() != 2) begin errors++; $display("FAIL read_tx_req_count: got %0d expected 2", tx_seen.size()); end
    checks++; if (iic_sda_out !== 1'b0) begin errors++; $display("FAIL read_release_after_nack: got %b expected 0", iic_sda_out); end
    checks++; if (iic_rw !== 1'b1) begin errors++; $display("FAIL read_rw: got %b expected 1", iic_rw); end
    bus_stop();
    checks++; if (stop_seen != 1) begin errors++; $display("FAIL read_stop_pulse: got %0d expected 1", stop_seen); end
    checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL read_busy_end: got %b expected 0", iic_busy); end
  endtask

  task automatic test_mismatch();
    logic [6:0] a;
    bit ack;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) a = 7'h51;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h50) a = 7'h2A;
      end
      clear_mon();
      bus_start();
      write_byte({a, n[0]}, ack);
      write_byte(8'h55, ack);
      checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy%0d: got %b expected 0", n, iic_busy); end
      bus_stop();
      checks++; if (drive_seen !== 1'b0) begin errors++; $display("FAIL mismatch_sda_driven%0d: got %b expected 0", n, drive_seen); end
      checks++; if (rx_seen.size() != 0) begin errors++; $display("FAIL mismatch_rx_vld%0d: got %0d expected 0", n, rx_seen.size()); end
      checks++; if (stop_seen != 0) begin errors++; $display("FAIL mismatch_stop%0d: got %0d expected 0", n, stop_seen); end
    end
  endtask

  task automatic test_repeated_start();
    logic [7:0] tx, b;
    bit ack1, ack2;
    clear_mon();
    tx = 8'($urandom);
    tx_data = tx;
    bus_start();
    write_byte(8'hA0, ack1);
    write_byte(8'h10, ack1);
    bus_start();
    write_byte(8'hA1, ack2);
    read_byte(b, 1'b0);
    checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL rs_addr_ack: got %b expected 1", ack2); end
    checks++; if (iic_rw !== 1'b1) begin errors++; $display("FAIL rs_rw: got %b expected 1", iic_rw); end
    bus_stop();
    checks++; if (rx_data !== 8'h10) begin errors++; $display("FAIL rs_rx_data: got %h expected 10", rx_data); end
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL rs_rx_count: got %0d expected 1", rx_seen.size()); end
    checks++; if (b !== tx) begin errors++; $display("FAIL rs_read_byte: got %h expected %h", b, tx); end
    checks++; if (tx_seen.size() != 1) begin errors++; $display("FAIL rs_tx_req_count: got %0d expected 1", tx_seen.size()); end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [7:0] d;
    bit ack;
    d = 8'($urandom);
    clear_mon();
    bus_start();
    write_byte(8'hA0, ack);
    for (int i = 7; i >= 4; i--) put_bit(d[i], 1'b0);
    if (use_rst) iic_rst = 1'b1; else iic_en = 1'b0;
    @(negedge clk);
    checks++; if (iic_sda_out !== 1'b0) begin errors++; $display("FAIL abort_release%0d: got %b expected 0", use_rst, iic_sda_out); end
    for (int i = 3; i >= 0; i--) put_bit(d[i], 1'b0);
    put_bit(1'b1, 1'b0);
    checks++; if (rx_seen.size() != 0) begin errors++; $display("FAIL abort_rx_vld%0d: got %0d expected 0", use_rst, rx_seen.size()); end
    if (use_rst) begin
      checks++; if (iic_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", iic_busy); end
    end
    iic_rst = 1'b0;
    iic_en  = 1'b1;
    repeat (4) @(negedge clk);
    clear_mon();
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL abort_next_ack%0d: got %b expected 1", use_rst, ack); end
    write_byte(8'h01, ack);
    bus_stop();
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL abort_next_rx%0d: got %h expected 01", use_rst, rx_data); end
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL abort_next_count%0d: got %0d expected 1", use_rst, rx_seen.size()); end
  endtask

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [7:0] d;
    bit ack;
    d = 8'($urandom);
    clear_mon();
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(d, ack, 3);
    bus_stop();
    checks++; if (rx_seen.size() != 1) begin errors++; $display("FAIL glitch_rx_count: got %0d expected 1", rx_seen.size()); end
    checks++; if (rx_data !== d) begin errors++; $display("FAIL glitch_rx_data: got %h expected %h", rx_data, d); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_abort(1'b1);
    test_abort(1'b0);
`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    checks++; if (iic_sda_o !== 1'b0) begin errors++; $display("FAIL sda_o_const: got %b expected 0", iic_sda_o); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
